instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
- Converts one-hot instruction flags plus register and immediate fields into 32-bit RV32I machine words. This is the inverse of the instruction decoder.
- Emits each word with an incrementing word address on a valid/ready stream.
- Sits between the test-program generator and the instruction-memory write port.
- Has a one-entry registered output stage and rejects malformed requests with error reporting.

Parameters:
ADDR_W, 10, width of instruction-memory word address; address counter wraps modulo 2^ADDR_W
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  single clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  encoder can accept request
in_flags  input  25  one-hot op select; encoding in enc_pkg
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  13  immediate: I-type uses [11:0]; shifts use [4:0]; branch uses [12:0]
addr_load  input  1  load address counter from addr_base
addr_base  input  ADDR_W  start address
out_valid  output  1  encoded word valid
out_ready  input  1  consumer accepts word
out_instr  output  32  encoded instruction
out_addr  output  ADDR_W  word address of out_instr
err  output  1  one-cycle pulse: a request was rejected
err_count  output  ERR_CNT_W  saturating count of rejected requests

Behaviour:
- Reset (async, rst=1): out_valid=0, out_instr=0, out_addr=0, err=0, err_count=0, address counter=0. Reset mid-transfer drops the held word.
- Handshakes:
  - in_ready = !out_valid || out_ready. Accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Latency: one cycle. A word accepted in cycle N is visible with out_valid=1 in cycle N+1.
  - out_instr and out_addr stay stable while out_valid && !out_ready.
  - Throughput: 1 word per cycle.
- Address:
  - A valid accept captures the counter into out_addr, then increments the counter (wrap to 0 at 2^ADDR_W-1).
  - addr_load sets the counter to addr_base and has priority over increment in the same cycle.
  - addr_load does not alter a held out_addr.
- Validation (combinational on the request; the checked request is consumed either way):
  - Rejection conditions:
    - in_flags not exactly one-hot (zero or ≥2 bits set);
    - shift-immediate op with in_imm[11:5]≠0;
    - branch with in_imm[0]=1.
  - On a rejected accept:
    - no word is produced; out_valid falls if the prior word transferred;
    - counter unchanged;
    - err=1 for exactly the next cycle;
    - err_count increments, saturating at all-ones.
- Encodings (opcode in [6:0]):
  - R-type 0110011: {f7,rs2,rs1,f3,rd,op}.
    - f3: add/sub=000, sll=001, slt=010, sltu=011, xor=100, srl/sra=101, or=110, and=111.
    - f7=0100000 for sub/sra, else 0.
  - I-type ALU 0010011: {imm[11:0],rs1,f3,rd,op}. f3 same as R-type (addi=000 … andi=111).
  - Shifts slli/srli/srai: {f7,imm[4:0],rs1,f3,rd,op}, with f7=0100000 only for srai.
  - B-type 1100011: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
    - f3: beq=000, bne=001, blt=100, bge=101, bltu=110, bgeu=111.
  - Fields unused by the format (e.g. rs2 for I-type) are ignored.

Decomposition:
- enc_pkg holds:
  - flag bit indices, LSB first: and,or,xor,sltu,slt,sll,sub,add,srai,srli,slli,andi,ori,xori,sltiu,slti,addi,beq,bge,bgeu,blt,bltu,bne,srl,sra;
  - opcode constants (OP_R, OP_I, OP_B);
  - funct3/funct7 constants.
- One combinational sub-module, instr_pack: flags+fields → {word, reject}.
- The top level holds the handshake register, address counter and error logic.

Test Plan:
- addi rd=1 rs1=0 imm=5, addr_load base=0 → out_instr=0x00500093, out_addr=0, one cycle after accept.
- Back-to-back sub rd=3 rs1=1 rs2=2 then srai rd=5 rs1=6 imm=3 → 0x402081B3 @1, 0x40335293 @2, no bubble.
- beq rs1=1 rs2=2 imm=8 with out_ready low 3 cycles → 0x00208463 held stable; in_ready=0 during stall; transfer on 4th cycle.
- Rejects:
  - flags with addi|add set → err pulse, err_count=1;
  - beq imm=3 → err_count=2;
  - slli imm=0x020 → err_count=3;
  - no out_valid and counter unchanged throughout.
- ADDR_W=2, five addi accepts → out_addr 0,1,2,3,0.
- addr_load base=2 coincident with accept → that word at current counter value; next word at 2.
- rst asserted while out_valid=1 and out_ready=0 → out_valid=0, counters 0 immediately (async).

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants for the RV32I instruction encoder: one-hot flag positions,
// opcodes, funct3/funct7 values and the output format selector.
package enc_pkg;

  localparam int FLAG_W = 25;

  localparam int F_AND   = 0;
  localparam int F_OR    = 1;
  localparam int F_XOR   = 2;
  localparam int F_SLTU  = 3;
  localparam int F_SLT   = 4;
  localparam int F_SLL   = 5;
  localparam int F_SUB   = 6;
  localparam int F_ADD   = 7;
  localparam int F_SRAI  = 8;
  localparam int F_SRLI  = 9;
  localparam int F_SLLI  = 10;
  localparam int F_ANDI  = 11;
  localparam int F_ORI   = 12;
  localparam int F_XORI  = 13;
  localparam int F_SLTIU = 14;
  localparam int F_SLTI  = 15;
  localparam int F_ADDI  = 16;
  localparam int F_BEQ   = 17;
  localparam int F_BGE   = 18;
  localparam int F_BGEU  = 19;
  localparam int F_BLT   = 20;
  localparam int F_BLTU  = 21;
  localparam int F_BNE   = 22;
  localparam int F_SRL   = 23;
  localparam int F_SRA   = 24;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_SH,
    FMT_B
  } fmt_e;

  function automatic logic is_onehot(input logic [FLAG_W-1:0] f);
    return (f != '0) && ((f & (f - FLAG_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: one-hot op flags plus register/immediate fields to an
// RV32I word, with a reject flag for malformed requests.
module instr_pack
  import enc_pkg::*;
(
  input  logic [FLAG_W-1:0] flags_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [12:0]       imm_i,
  output logic [31:0]       word_o,
  output logic              reject_o
);

  fmt_e       fmt;
  logic [2:0] f3;
  logic [6:0] f7;

  always_comb begin
    fmt = FMT_R;
    f3  = F3_ADD;
    f7  = F7_BASE;
    // Register-register ALU ops
    if (flags_i[F_SUB])  f7 = F7_ALT;
    if (flags_i[F_SLL])  f3 = F3_SLL;
    if (flags_i[F_SLT])  f3 = F3_SLT;
    if (flags_i[F_SLTU]) f3 = F3_SLTU;
    if (flags_i[F_XOR])  f3 = F3_XOR;
    if (flags_i[F_SRL])  f3 = F3_SR;
    if (flags_i[F_SRA])  begin f3 = F3_SR; f7 = F7_ALT; end
    if (flags_i[F_OR])   f3 = F3_OR;
    if (flags_i[F_AND])  f3 = F3_AND;
    // Register-immediate ALU ops
    if (flags_i[F_ADDI])  begin fmt = FMT_I; f3 = F3_ADD;  end
    if (flags_i[F_SLTI])  begin fmt = FMT_I; f3 = F3_SLT;  end
    if (flags_i[F_SLTIU]) begin fmt = FMT_I; f3 = F3_SLTU; end
    if (flags_i[F_XORI])  begin fmt = FMT_I; f3 = F3_XOR;  end
    if (flags_i[F_ORI])   begin fmt = FMT_I; f3 = F3_OR;   end
    if (flags_i[F_ANDI])  begin fmt = FMT_I; f3 = F3_AND;  end
    if (flags_i[F_SLLI])  begin fmt = FMT_SH; f3 = F3_SLL; end
    if (flags_i[F_SRLI])  begin fmt = FMT_SH; f3 = F3_SR;  end
    if (flags_i[F_SRAI])  begin fmt = FMT_SH; f3 = F3_SR; f7 = F7_ALT; end
    // Branches
    if (flags_i[F_BEQ])  begin fmt = FMT_B; f3 = F3_BEQ;  end
    if (flags_i[F_BNE])  begin fmt = FMT_B; f3 = F3_BNE;  end
    if (flags_i[F_BLT])  begin fmt = FMT_B; f3 = F3_BLT;  end
    if (flags_i[F_BGE])  begin fmt = FMT_B; f3 = F3_BGE;  end
    if (flags_i[F_BLTU]) begin fmt = FMT_B; f3 = F3_BLTU; end
    if (flags_i[F_BGEU]) begin fmt = FMT_B; f3 = F3_BGEU; end
  end

  always_comb begin
    word_o = '0;
    case (fmt)
      FMT_R:   word_o = {f7, rs2_i, rs1_i, f3, rd_i, OP_R};
      FMT_I:   word_o = {imm_i[11:0], rs1_i, f3, rd_i, OP_I};
      FMT_SH:  word_o = {f7, imm_i[4:0], rs1_i, f3, rd_i, OP_I};
      FMT_B:   word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3,
                         imm_i[4:1], imm_i[11], OP_B};
      default: word_o = '0;
    endcase
  end

  // The shift and branch checks only matter once the flags name a single op.
  assign reject_o = !is_onehot(flags_i)
                  || ((fmt == FMT_SH) && (imm_i[11:5] != 7'd0))
                  || ((fmt == FMT_B) && imm_i[0]);

endmodule

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: packs requests into machine words, stamps each with
// an incrementing word address and presents them on a one-entry output register.
module instruction_encoder
  import enc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLAG_W-1:0]    in_flags,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [12:0]          in_imm,
  input  logic                 addr_load,
  input  logic [ADDR_W-1:0]    addr_base,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [31:0] word;
  logic        reject;

  instr_pack u_pack (
    .flags_i  (in_flags),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .imm_i    (in_imm),
    .word_o   (word),
    .reject_o (reject)
  );

  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]    out_addr_q,  out_addr_d;
  logic [ADDR_W-1:0]    cnt_q,       cnt_d;
  logic                 err_q,       err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;
  logic                 accept, good, bad;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign good     = accept && !reject;
  assign bad      = accept && reject;

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    cnt_d       = cnt_q;
    err_d       = bad;
    err_cnt_d   = err_cnt_q;
    if (good) begin
      out_valid_d = 1'b1;
      out_instr_d = word;
      out_addr_d  = cnt_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // A load wins over the post-accept increment; the held word keeps its address.
    if (addr_load) begin
      cnt_d = addr_base;
    end else if (good) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
    if (bad && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: vector table of encodings/rejects,
// then stall, address-load and asynchronous-reset sequences.
module tb_instruction_encoder;

  localparam logic [24:0] AND_  = 25'd1 << 0;
  localparam logic [24:0] OR_   = 25'd1 << 1;
  localparam logic [24:0] SLTU  = 25'd1 << 3;
  localparam logic [24:0] SUB   = 25'd1 << 6;
  localparam logic [24:0] ADD   = 25'd1 << 7;
  localparam logic [24:0] SRAI  = 25'd1 << 8;
  localparam logic [24:0] SRLI  = 25'd1 << 9;
  localparam logic [24:0] SLLI  = 25'd1 << 10;
  localparam logic [24:0] ANDI  = 25'd1 << 11;
  localparam logic [24:0] XORI  = 25'd1 << 13;
  localparam logic [24:0] SLTIU = 25'd1 << 14;
  localparam logic [24:0] SLTI  = 25'd1 << 15;
  localparam logic [24:0] ADDI  = 25'd1 << 16;
  localparam logic [24:0] BEQ   = 25'd1 << 17;
  localparam logic [24:0] BGEU  = 25'd1 << 19;
  localparam logic [24:0] BLT   = 25'd1 << 20;
  localparam logic [24:0] BLTU  = 25'd1 << 21;
  localparam logic [24:0] BNE   = 25'd1 << 22;
  localparam logic [24:0] SRL   = 25'd1 << 23;
  localparam logic [24:0] SRA   = 25'd1 << 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [24:0] in_flags = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [12:0] in_imm = '0;
  logic        addr_load = 1'b0;
  logic [9:0]  addr_base = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, err;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic [7:0]  err_count;

  logic        in_ready2, out_valid2, err2;
  logic [31:0] out_instr2;
  logic [1:0]  out_addr2;
  logic [1:0]  err_count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_encoder #(.ADDR_W(10), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_flags(in_flags), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .addr_load(addr_load), .addr_base(addr_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .err_count(err_count)
  );

  // Narrow instance shares the stimulus to exercise address wrap and counter saturation.
  instruction_encoder #(.ADDR_W(2), .ERR_CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_flags(in_flags), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .addr_load(addr_load), .addr_base(addr_base[1:0]),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_addr(out_addr2), .err(err2), .err_count(err_count2)
  );

  typedef struct {
    logic [24:0] flags;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] imm;
    logic [31:0] instr;
    logic        rej;
  } vec_t;

  localparam int NV = 25;
  vec_t tv[NV];

  function automatic vec_t mk(input logic [24:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [12:0] imm,
                              input logic [31:0] instr, input logic rej);
    vec_t v;
    v.flags = f; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.instr = instr; v.rej = rej;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [24:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [12:0] imm);
    in_valid = 1'b1; in_flags = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_addr;
    int exp_ec;

    tv[0]  = mk(ADDI,       5'd1,  5'd0,  5'd0,  13'd5,     32'h00500093, 1'b0);
    tv[1]  = mk(SUB,        5'd3,  5'd1,  5'd2,  13'd0,     32'h402081B3, 1'b0);
    tv[2]  = mk(SRAI,       5'd5,  5'd6,  5'd0,  13'd3,     32'h40335293, 1'b0);
    tv[3]  = mk(BEQ,        5'd0,  5'd1,  5'd2,  13'd8,     32'h00208463, 1'b0);
    tv[4]  = mk(ADDI | ADD, 5'd1,  5'd0,  5'd0,  13'd5,     32'h0,        1'b1);
    tv[5]  = mk(ADD,        5'd1,  5'd2,  5'd3,  13'd0,     32'h003100B3, 1'b0);
    tv[6]  = mk(BEQ,        5'd0,  5'd1,  5'd2,  13'd3,     32'h0,        1'b1);
    tv[7]  = mk(AND_,       5'd10, 5'd11, 5'd12, 13'd0,     32'h00C5F533, 1'b0);
    tv[8]  = mk(SLLI,       5'd1,  5'd1,  5'd0,  13'h020,   32'h0,        1'b1);
    tv[9]  = mk(SRA,        5'd1,  5'd2,  5'd3,  13'd0,     32'h403150B3, 1'b0);
    tv[10] = mk(SRL,        5'd1,  5'd2,  5'd3,  13'd0,     32'h003150B3, 1'b0);
    tv[11] = mk(SLTU,       5'd1,  5'd2,  5'd3,  13'd0,     32'h003130B3, 1'b0);
    tv[12] = mk(25'd0,      5'd1,  5'd2,  5'd3,  13'd0,     32'h0,        1'b1);
    tv[13] = mk(ANDI,       5'd2,  5'd3,  5'd0,  13'hFFF,   32'hFFF1F113, 1'b0);
    tv[14] = mk(SLLI,       5'd1,  5'd1,  5'd0,  13'd31,    32'h01F09093, 1'b0);
    tv[15] = mk(SRLI,       5'd1,  5'd1,  5'd0,  13'h040,   32'h0,        1'b1);
    tv[16] = mk(BNE,        5'd0,  5'd1,  5'd2,  13'h1FFE,  32'hFE209FE3, 1'b0);
    tv[17] = mk(BGEU,       5'd0,  5'd5,  5'd6,  13'h800,   32'h0062F0E3, 1'b0);
    tv[18] = mk(SRAI,       5'd1,  5'd1,  5'd0,  13'h403,   32'h0,        1'b1);
    tv[19] = mk(SLTI,       5'd1,  5'd0,  5'd0,  13'h800,   32'h80002093, 1'b0);
    tv[20] = mk(XORI,       5'd1,  5'd1,  5'd0,  13'd1,     32'h0010C093, 1'b0);
    tv[21] = mk(OR_,        5'd1,  5'd2,  5'd3,  13'd0,     32'h003160B3, 1'b0);
    tv[22] = mk(BLTU,       5'd0,  5'd1,  5'd2,  13'h010,   32'h0020E863, 1'b0);
    tv[23] = mk(SLTIU,      5'd1,  5'd2,  5'd0,  13'd7,     32'h00713093, 1'b0);
    tv[24] = mk(BLT,        5'd0,  5'd3,  5'd4,  13'h020,   32'h0241C063, 1'b0);

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr",  32'(out_addr), 32'd0);
    chk("rst_err",       32'(err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;

    exp_addr = 0;
    exp_ec   = 0;
    for (int i = 0; i < NV; i++) begin
      drive(tv[i].flags, tv[i].rd, tv[i].rs1, tv[i].rs2, tv[i].imm);
      tick();
      if (tv[i].rej) begin
        exp_ec++;
        chk($sformatf("v%0d_valid_rej", i), 32'(out_valid), 32'd0);
      end else begin
        chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d_instr", i), out_instr, tv[i].instr);
        chk($sformatf("v%0d_addr", i), 32'(out_addr), 32'(exp_addr));
        chk($sformatf("v%0d_addr_w2", i), 32'(out_addr2), 32'(exp_addr % 4));
        exp_addr++;
      end
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tv[i].rej));
      chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(exp_ec));
      chk($sformatf("v%0d_err_count_w2", i), 32'(err_count2), 32'((exp_ec > 3) ? 3 : exp_ec));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_err", 32'(err), 32'd0);

    // Stall: beq held for three cycles while another request waits.
    out_ready = 1'b0;
    drive(BEQ, 5'd0, 5'd1, 5'd2, 13'd8);
    tick();
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_instr", out_instr, 32'h00208463);
    chk("stall_addr", 32'(out_addr), 32'(exp_addr));
    drive(ADDI, 5'd1, 5'd0, 5'd0, 13'd5);
    addr_load = 1'b1;
    addr_base = 10'h055;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
      tick();
      addr_load = 1'b0;
      chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_instr", k), out_instr, 32'h00208463);
      chk($sformatf("stall%0d_addr", k), 32'(out_addr), 32'(exp_addr));
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("after_stall_instr", out_instr, 32'h00500093);
    chk("after_stall_addr", 32'(out_addr), 32'h055);
    chk("after_stall_addr_w2", 32'(out_addr2), 32'd1);

    // Load coincident with an accept: this word keeps the old counter.
    addr_load = 1'b1;
    addr_base = 10'd2;
    tick();
    addr_load = 1'b0;
    chk("load_same_cycle_addr", 32'(out_addr), 32'h056);
    tick();
    chk("load_next_addr", 32'(out_addr), 32'd2);
    chk("load_next_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();

    // Asynchronous reset while a word is held.
    out_ready = 1'b0;
    drive(ADDI, 5'd1, 5'd0, 5'd0, 13'd5);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_instr", out_instr, 32'd0);
    chk("async_rst_addr", 32'(out_addr), 32'd0);
    chk("async_rst_err_count", 32'(err_count), 32'd0);
    chk("async_rst_err_count_w2", 32'(err_count2), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(ADDI, 5'd1, 5'd0, 5'd0, 13'd5);
    tick();
    in_valid = 1'b0;
    chk("post_rst_addr", 32'(out_addr), 32'd0);
    chk("post_rst_instr", out_instr, 32'h00500093);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
